// File: rtl/neighbor_reader.sv
// Neighbour-list reader: looks up a vertex's adjacency list in a synchronous-read RAM
// and streams the neighbours out one beat at a time over a valid/ready handshake.
module neighbor_reader #(
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int ADDR_WIDTH         = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           vertex_count,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_vertex,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_neighbor,
  output logic                  out_last,
  output logic                  out_empty,
  output logic                  out_err,
  output logic [3:0]            out_count,
  output logic                  RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [3:0]            RAM_NBR_WE,
  output logic [31:0]           RAM_NBR_Di,
  input  logic [31:0]           RAM_NBR_Do,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_WAIT,
    S_CNT_CAP,
    S_NBR_WAIT,
    S_NBR_CAP,
    S_OUT
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_busy;
  logic                  r_ram_en;
  logic [ADDR_WIDTH-1:0] r_ram_a;
  logic [3:0]            r_count;
  logic [3:0]            r_idx;
  logic                  r_empty;
  logic                  r_err;
  logic                  r_out_valid;
  logic [31:0]           r_out_neighbor;
  logic                  r_out_last;
  logic                  r_out_empty;
  logic                  r_out_err;
  logic [3:0]            r_out_count;

  logic                  w_bad;
  logic [ADDR_WIDTH-1:0] w_vm1;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [3:0]            w_cnt_raw;
  logic [3:0]            w_cnt_clamped;

  assign w_bad         = (req_vertex == 32'd0) || (req_vertex > vertex_count);
  assign w_vm1         = req_vertex[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign w_base        = w_vm1 * ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);
  assign w_cnt_raw     = RAM_NBR_Do[3:0];
  assign w_cnt_clamped = (32'(w_cnt_raw) > 32'(MAX_NEIGHBOR_COUNT)) ?
                         4'(MAX_NEIGHBOR_COUNT) : w_cnt_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_req_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_ram_en       <= 1'b0;
      r_ram_a        <= '0;
      r_count        <= '0;
      r_idx          <= '0;
      r_empty        <= 1'b0;
      r_err          <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_neighbor <= '0;
      r_out_last     <= 1'b0;
      r_out_empty    <= 1'b0;
      r_out_err      <= 1'b0;
      r_out_count    <= '0;
    end else begin
      r_ram_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_empty     <= 1'b0;
            r_err       <= w_bad;
            // Bad vertices skip the RAM and reuse NBR_CAP to present the error beat.
            if (w_bad) begin
              r_state <= S_NBR_CAP;
            end else begin
              r_ram_a  <= w_base;
              r_ram_en <= 1'b1;
              r_state  <= S_CNT_WAIT;
            end
          end
        end
        S_CNT_WAIT: r_state <= S_CNT_CAP;
        S_CNT_CAP: begin
          r_count <= w_cnt_clamped;
          r_idx   <= '0;
          // An empty list still walks NBR_WAIT/NBR_CAP so every valid lookup has equal latency.
          if (w_cnt_clamped == 4'd0) begin
            r_empty <= 1'b1;
          end else begin
            r_ram_a  <= r_ram_a + ADDR_WIDTH'(1);
            r_ram_en <= 1'b1;
          end
          r_state <= S_NBR_WAIT;
        end
        S_NBR_WAIT: r_state <= S_NBR_CAP;
        S_NBR_CAP: begin
          r_out_valid <= 1'b1;
          r_out_err   <= r_err;
          if (r_err || r_empty) begin
            r_out_neighbor <= '0;
            r_out_last     <= 1'b1;
            r_out_empty    <= r_empty;
            r_out_count    <= '0;
          end else begin
            r_out_neighbor <= RAM_NBR_Do;
            r_out_last     <= (r_idx == r_count - 4'd1);
            r_out_empty    <= 1'b0;
            r_out_count    <= r_count;
          end
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_busy      <= 1'b0;
              r_req_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_idx    <= r_idx + 4'd1;
              r_ram_a  <= r_ram_a + ADDR_WIDTH'(1);
              r_ram_en <= 1'b1;
              r_state  <= S_NBR_WAIT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign busy         = r_busy;
  assign out_valid    = r_out_valid;
  assign out_neighbor = r_out_neighbor;
  assign out_last     = r_out_last;
  assign out_empty    = r_out_empty;
  assign out_err      = r_out_err;
  assign out_count    = r_out_count;
  assign RAM_NBR_EN   = r_ram_en;
  assign RAM_NBR_A    = r_ram_a;
  assign RAM_NBR_WE   = '0;
  assign RAM_NBR_Di   = '0;

endmodule

// File: tb/tb_neighbor_reader.sv
// Directed, table-driven bench for neighbor_reader with a behavioural synchronous RAM.
module tb_neighbor_reader;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   vertex_count = 32'd4;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_vertex = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_neighbor;
  logic          out_last;
  logic          out_empty;
  logic          out_err;
  logic [3:0]    out_count;
  logic          RAM_NBR_EN;
  logic [AW-1:0] RAM_NBR_A;
  logic [3:0]    RAM_NBR_WE;
  logic [31:0]   RAM_NBR_Di;
  logic [31:0]   RAM_NBR_Do = '0;
  logic          busy;

  logic [31:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;
  int en_count = 0;

  neighbor_reader #(.MAX_NEIGHBOR_COUNT(10), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .vertex_count(vertex_count),
    .req_valid(req_valid), .req_ready(req_ready), .req_vertex(req_vertex),
    .out_valid(out_valid), .out_ready(out_ready), .out_neighbor(out_neighbor),
    .out_last(out_last), .out_empty(out_empty), .out_err(out_err),
    .out_count(out_count), .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A),
    .RAM_NBR_WE(RAM_NBR_WE), .RAM_NBR_Di(RAM_NBR_Di), .RAM_NBR_Do(RAM_NBR_Do),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RAM_NBR_EN === 1'b1) begin
      RAM_NBR_Do <= mem[RAM_NBR_A];
      en_count   <= en_count + 1;
    end
  end

  typedef struct {
    logic [31:0]      vertex;
    int               nb;
    logic [3:0]       cnt;
    logic             empty;
    logic             err;
    int               lat;
    int               reads;
    logic [9:0][31:0] nbr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input int stall_beat);
    int t, lat, en0;
    logic [31:0] hold_nbr;
    logic hold_last;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_vertex = v.vertex;
    en0 = en_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin lat++; @(negedge clk); end
    check("latency", lat, v.lat);
    check("busy_active", {31'd0, busy}, 32'd1);
    for (int b = 0; b < v.nb; b++) begin
      if (b > 0) begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 20) begin t++; @(negedge clk); end
        check("beat_valid", {31'd0, out_valid}, 32'd1);
      end
      check("neighbor", out_neighbor, v.nbr[b]);
      check("last", {31'd0, out_last}, {31'd0, (b == v.nb - 1)});
      check("count", {28'd0, out_count}, {28'd0, v.cnt});
      check("empty", {31'd0, out_empty}, {31'd0, v.empty});
      check("err", {31'd0, out_err}, {31'd0, v.err});
      check("we_di", {RAM_NBR_WE, RAM_NBR_Di[27:0]}, 32'd0);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        hold_nbr  = out_neighbor;
        hold_last = out_last;
        t = en_count;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_nbr", out_neighbor, hold_nbr);
          check("stall_last", {31'd0, out_last}, {31'd0, hold_last});
          check("stall_no_read", en_count, t);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("done_valid", {31'd0, out_valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_ready", {31'd0, req_ready}, 32'd1);
    check("ram_reads", en_count - en0, v.reads);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'd0;
    mem[10] = 32'd2;  mem[11] = 32'd42; mem[12] = 32'd43;
    mem[20] = 32'h13; mem[21] = 32'd5;  mem[22] = 32'd7;  mem[23] = 32'd9;
    mem[30] = 32'hABCD_000F;
    for (int k = 0; k < 10; k++) mem[31 + k] = 32'd100 + 32'(k);
    mem[41] = 32'd999;

    vecs[0] = '{vertex: 32'd1, nb: 1, cnt: 4'd0, empty: 1'b1, err: 1'b0, lat: 4, reads: 1, nbr: '0};
    vecs[1] = '{vertex: 32'd2, nb: 2, cnt: 4'd2, empty: 1'b0, err: 1'b0, lat: 4, reads: 3, nbr: '0};
    vecs[1].nbr[0] = 32'd42; vecs[1].nbr[1] = 32'd43;
    vecs[2] = '{vertex: 32'd3, nb: 3, cnt: 4'd3, empty: 1'b0, err: 1'b0, lat: 4, reads: 4, nbr: '0};
    vecs[2].nbr[0] = 32'd5; vecs[2].nbr[1] = 32'd7; vecs[2].nbr[2] = 32'd9;
    vecs[3] = '{vertex: 32'd4, nb: 10, cnt: 4'd10, empty: 1'b0, err: 1'b0, lat: 4, reads: 11, nbr: '0};
    for (int k = 0; k < 10; k++) vecs[3].nbr[k] = 32'd100 + 32'(k);
    vecs[4] = '{vertex: 32'd0, nb: 1, cnt: 4'd0, empty: 1'b0, err: 1'b1, lat: 1, reads: 0, nbr: '0};
    vecs[5] = '{vertex: 32'd5, nb: 1, cnt: 4'd0, empty: 1'b0, err: 1'b1, lat: 1, reads: 0, nbr: '0};
    vecs[6] = '{vertex: 32'h0000_0203, nb: 1, cnt: 4'd0, empty: 1'b0, err: 1'b1, lat: 1, reads: 0, nbr: '0};

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_outs", {out_valid, out_last, out_empty, out_err, out_count, RAM_NBR_EN, busy}, 32'd0);
    check("rst_addr", {23'd0, RAM_NBR_A}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_req(vecs[i], -1);

    do_req(vecs[2], 1);

    @(negedge clk);
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    out_ready  = 1'b0;
    req_valid  = 1'b1;
    req_vertex = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin t++; @(negedge clk); end
    check("pre_reset_beat", out_neighbor, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {out_valid, out_last, out_empty, out_err, out_count, RAM_NBR_EN, busy, req_ready}, 32'd0);
    check("mid_rst_nbr", out_neighbor, 32'd0);
    check("mid_rst_addr", {23'd0, RAM_NBR_A}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    do_req(vecs[2], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
